// File: rtl/rgd_sync_responder_pkg.sv
// +----------------------------------------------------------------------+
// | rgd_pkg : shared types and constants for rgd_sync_responder          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package rgd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } rgd_state_t;

  localparam int DEF_SYNC_STAGES = 2;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rgd_sync_responder_phase_sync.sv
// +----------------------------------------------------------------------+
// | phase_sync : STAGES-deep synchronizer for a two-phase request line   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module phase_sync
  import rgd_pkg::*;
#(
  parameter int   STAGES = DEF_SYNC_STAGES,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Preset to the idle phase so the chain never reports a phantom request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{INIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rgd_sync_responder.sv
// +----------------------------------------------------------------------+
// | rgd_sync_responder : two-channel RGD click responder, round-robin    |
// | Optional watchdog enabled by macro RGD_TIMEOUT_EN                    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rgd_sync_responder
  import rgd_pkg::*;
#(
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter logic PHASE_INIT_A   = 1'b0,
  parameter logic PHASE_INIT_B   = 1'b0,
  parameter logic FIRST_PRIO     = CH_A,
  parameter int   TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  output logic ack_a,
  input  logic req_b,
  output logic ack_b,
  output logic gnt_a,
  output logic gnt_b,
  input  logic done,
  output logic busy,
  output logic timeout_err
);

  rgd_state_t state_q, state_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       rr_q, rr_d;
  logic       w_req_a_s, w_req_b_s;
  logic       w_pend_a, w_pend_b;
  logic       w_expire;
  logic       w_finish;

  phase_sync #(.STAGES(SYNC_STAGES), .INIT(PHASE_INIT_A)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (req_a),
    .q   (w_req_a_s)
  );

  phase_sync #(.STAGES(SYNC_STAGES), .INIT(PHASE_INIT_B)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (req_b),
    .q   (w_req_b_s)
  );

  assign w_pend_a = w_req_a_s ^ ack_a_q;
  assign w_pend_b = w_req_b_s ^ ack_b_q;

`ifdef RGD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter reads 0 in the first grant cycle, so expiry releases the grant
  // after exactly TIMEOUT_CYCLES cycles; a real done always wins.
  always_comb begin
    cnt_d    = '0;
    err_d    = err_q;
    w_expire = (state_q != IDLE) && !done && (cnt_q == c_to_last);
    if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (w_expire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err      = 1'b0;
`endif

  assign w_finish = done | w_expire;

  always_comb begin
    state_d = state_q;
    ack_a_d = ack_a_q;
    ack_b_d = ack_b_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (w_pend_a && w_pend_b) begin
          state_d = (rr_q == CH_A) ? GNT_A : GNT_B;
        end else if (w_pend_a) begin
          state_d = GNT_A;
        end else if (w_pend_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (w_finish) begin
          state_d = IDLE;
          ack_a_d = ~ack_a_q;
          rr_d    = CH_B;
        end
      end
      GNT_B: begin
        if (w_finish) begin
          state_d = IDLE;
          ack_b_d = ~ack_b_q;
          rr_d    = CH_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_a_q <= PHASE_INIT_A;
      ack_b_q <= PHASE_INIT_B;
      rr_q    <= FIRST_PRIO;
    end else begin
      state_q <= state_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt_a = (state_q == GNT_A);
  assign gnt_b = (state_q == GNT_B);
  assign busy  = gnt_a | gnt_b;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;

endmodule

`default_nettype wire

// File: tb/tb_rgd_sync_responder.sv
// +----------------------------------------------------------------------+
// | tb_rgd_sync_responder : scoreboard bench for rgd_sync_responder      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rgd_sync_responder;

  localparam logic PIA = 1'b1;
  localparam logic PIB = 1'b0;
  localparam logic FP  = 1'b0;
  localparam int   TO  = 8;

  typedef struct { bit ch; bit b2b; } gexp_t;
  typedef struct { bit ch; bit val; bit to; } aexp_t;

  logic clk = 1'b0;
  logic rst, req_a, req_b, done_auto, done_man, done;
  logic ack_a, ack_b, gnt_a, gnt_b, busy, timeout_err;

  int    n_vec = 0;
  int    n_err = 0;
  gexp_t gnt_q[$];
  aexp_t ack_q[$];
  bit    rr_m;
  bit    withhold;
  int    hold_target;

  assign done = done_auto | done_man;

  rgd_sync_responder #(
    .SYNC_STAGES   (2),
    .PHASE_INIT_A  (PIA),
    .PHASE_INIT_B  (PIB),
    .FIRST_PRIO    (FP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .ack_a      (ack_a),
    .req_b      (req_b),
    .ack_b      (ack_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .done       (done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the DUT saw at the last active edge.
  logic rst_e, done_e;
  always @(posedge clk) begin
    rst_e  <= rst;
    done_e <= done;
  end

  // Monitor: pops expectations whenever a grant rises or an ack toggles.
  logic [1:0] pg = 2'b00;
  logic [1:0] pk = 2'b00;
  int         cyc = 0;
  int         end_cyc = 0;
  gexp_t      ge;
  aexp_t      ae;

  always @(negedge clk) begin
    logic [1:0] gv, av;
    gv = {gnt_b, gnt_a};
    av = {ack_b, ack_a};
    cyc++;
    if (rst_e === 1'b0) begin
      chk("exclusive", {31'd0, gv[0] & gv[1]}, 0);
      chk("busy", {31'd0, busy}, {31'd0, gv[0] | gv[1]});
      if ((gv & ~pg) != 2'b00) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", {30'd0, gv}, 0);
        end else begin
          ge = gnt_q.pop_front();
          chk("grant_ch", {31'd0, gv[1]}, {31'd0, ge.ch});
          if (ge.b2b) chk("b2b_idle_gap", cyc - end_cyc, 1);
        end
      end
      if ((pg & ~gv) != 2'b00) end_cyc = cyc;
      for (int c = 0; c < 2; c++) begin
        if (av[c] !== pk[c]) begin
          if (ack_q.size() == 0) begin
            chk("unexpected_ack_toggle", {31'd0, av[c] ^ pk[c]}, 0);
          end else begin
            ae = ack_q.pop_front();
            chk("ack_ch", c, {31'd0, ae.ch});
            chk("ack_val", {31'd0, av[c]}, {31'd0, ae.val});
            chk("gnt_drop_with_ack", {31'd0, pg[c] & ~gv[c]}, 1);
            if (ae.to) chk("timeout_flag_at_ack", {31'd0, timeout_err}, 1);
            else       chk("done_before_ack", {31'd0, done_e}, 1);
          end
        end
      end
    end
    pg = gv;
    pk = av;
  end

  // Resource model: pulses done hold_target cycles into each grant.
  initial begin
    int hc;
    hc        = 0;
    done_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done_auto) begin
        done_auto = 1'b0;
        hc        = 0;
      end else if (busy && !withhold && !rst) begin
        if (hc >= hold_target) begin
          done_auto   = 1'b1;
          hold_target = $urandom_range(0, 4);
        end else begin
          hc++;
        end
      end else begin
        hc = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // A request is answered by an ack equal to the new request phase.
  task automatic toggle(input bit c, input bit to);
    if (c == 1'b0) begin
      req_a = ~req_a;
      ack_q.push_back('{ch: 1'b0, val: req_a, to: to});
    end else begin
      req_b = ~req_b;
      ack_q.push_back('{ch: 1'b1, val: req_b, to: to});
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = PIA;
    req_b = PIB;
    tick(2);
    rst = 1'b0;
    gnt_q.delete();
    ack_q.delete();
    rr_m = FP;
  endtask

  task automatic wait_gnt(input bit c, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (((c ? gnt_b : gnt_a) !== 1'b1) && n < 50);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || ack_q.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    if (gnt_q.size() != 0 || ack_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d grants and %0d acks still outstanding, expected 0",
               gnt_q.size(), ack_q.size());
      gnt_q.delete();
      ack_q.delete();
    end
    tick(2);
  endtask

  task automatic single(input bit c);
    gnt_q.push_back('{ch: c, b2b: 1'b0});
    toggle(c, 1'b0);
    rr_m = ~c;
  endtask

  task automatic both();
    bit first;
    first = rr_m;
    gnt_q.push_back('{ch: first, b2b: 1'b0});
    gnt_q.push_back('{ch: ~first, b2b: 1'b1});
    toggle(first, 1'b0);
    toggle(~first, 1'b0);
    rr_m = first;
  endtask

  task automatic delayed(input bit c, input int k, input bit b2b);
    gnt_q.push_back('{ch: c, b2b: 1'b0});
    gnt_q.push_back('{ch: ~c, b2b: b2b});
    toggle(c, 1'b0);
    tick(k);
    toggle(~c, 1'b0);
    rr_m = c;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    req_a       = PIA;
    req_b       = PIB;
    rst         = 1'b1;
    done_man    = 1'b0;
    withhold    = 1'b0;
    hold_target = 1;
    rr_m        = FP;

    do_reset();
    chk("rst_ack_a", {31'd0, ack_a}, {31'd0, PIA});
    chk("rst_ack_b", {31'd0, ack_b}, {31'd0, PIB});
    chk("rst_gnt", {30'd0, gnt_b, gnt_a}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    tick(10);
    chk("no_grant_after_rst", {31'd0, busy}, 0);

    // Latency: request to grant, then done to ack on the same edge.
    hold_target = 2;
    single(1'b0);
    wait_gnt(1'b0, n);
    chk("req_to_gnt_latency", n, 3);
    tick(3);
    chk("gnt_a_low_after_done", {31'd0, gnt_a}, 0);
    chk("ack_a_after_done", {31'd0, ack_a}, {31'd0, req_a});
    drain();

    // done while idle is ignored.
    done_man = 1'b1;
    tick(1);
    done_man = 1'b0;
    tick(3);
    chk("idle_done_ack_a", {31'd0, ack_a}, {31'd0, req_a});
    chk("idle_done_ack_b", {31'd0, ack_b}, {31'd0, req_b});

    // Simultaneous requests, served by the pointer order.
    do_reset();
    hold_target = 1;
    both();
    drain();
    both();
    drain();

    // B arrives during A's grant and must wait for A to finish.
    hold_target = 6;
    gnt_q.push_back('{ch: 1'b0, b2b: 1'b0});
    gnt_q.push_back('{ch: 1'b1, b2b: 1'b1});
    toggle(1'b0, 1'b0);
    tick(4);
    toggle(1'b1, 1'b0);
    rr_m = 1'b0;
    tick(3);
    chk("a_holds_during_b_req", {31'd0, gnt_a}, 1);
    chk("b_waits_during_a", {31'd0, gnt_b}, 0);
    drain();

    // Reset in the middle of a B grant.
    withhold = 1'b1;
    gnt_q.push_back('{ch: 1'b1, b2b: 1'b0});
    toggle(1'b1, 1'b0);
    wait_gnt(1'b1, n);
    chk("gnt_b_before_rst", {31'd0, gnt_b}, 1);
    tick(2);
    rst   = 1'b1;
    req_a = PIA;
    req_b = PIB;
    tick(1);
    rst = 1'b0;
    gnt_q.delete();
    ack_q.delete();
    rr_m     = FP;
    withhold = 1'b0;
    chk("rst_mid_gnt_b", {31'd0, gnt_b}, 0);
    chk("rst_mid_ack_b", {31'd0, ack_b}, {31'd0, PIB});
    tick(5);
    chk("rst_mid_idle", {31'd0, busy}, 0);

`ifdef RGD_TIMEOUT_EN
    withhold = 1'b1;
    gnt_q.push_back('{ch: 1'b0, b2b: 1'b0});
    toggle(1'b0, 1'b1);
    rr_m = 1'b1;
    wait_gnt(1'b0, n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (gnt_a === 1'b1 && n < 50);
    chk("timeout_grant_len", n, TO);
    chk("timeout_err_set", {31'd0, timeout_err}, 1);
    chk("timeout_ack_a", {31'd0, ack_a}, {31'd0, req_a});
    withhold = 1'b0;
    drain();
    single(1'b0);
    drain();
    chk("timeout_err_sticky", {31'd0, timeout_err}, 1);
`else
    withhold = 1'b1;
    single(1'b0);
    wait_gnt(1'b0, n);
    tick(30);
    chk("grant_held_without_done", {31'd0, gnt_a}, 1);
    chk("timeout_err_tied_low", {31'd0, timeout_err}, 0);
    withhold = 1'b0;
    drain();
`endif

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      int pat;
      bit c;
      pat = $urandom_range(0, 3);
      c   = 1'($urandom_range(0, 1));
      case (pat)
        0: single(c);
        1: both();
        2: delayed(c, $urandom_range(1, 4), 1'b0);
        default: begin
          done_man = 1'b1;
          tick(1);
          done_man = 1'b0;
          tick(2);
          chk("rand_idle_done_ack_a", {31'd0, ack_a}, {31'd0, req_a});
          chk("rand_idle_done_ack_b", {31'd0, ack_b}, {31'd0, req_b});
        end
      endcase
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
